// File: rtl/seqlock_pkg.sv
// Shared types and keypad helpers for the multi-digit sequence lock.
package seqlock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_e;

  function automatic logic is_onehot(input logic [9:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 10; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n == 4'd1;
  endfunction

  function automatic logic [3:0] keyenc(input logic [9:0] v);
    logic [3:0] d;
    d = '0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) d = 4'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/seqlock_if.sv
// Keypad/actuator bundle between scanner, lock core and door driver.
interface seqlock_if #(
  parameter int unsigned DIGITS = 4
);
  logic [9:0]                     tenkey;
  logic                           close;
  logic                           lock;
  logic                           alarm;
  logic                           err;
  logic [$clog2(DIGITS+1)-1:0]    digits;

  modport master (output tenkey, output close, input lock, input alarm, input err, input digits);
  modport slave  (input tenkey, input close, output lock, output alarm, output err, output digits);
endinterface

// File: rtl/seqlock_tenkey_enc.sv
// Two-stage keypad sampler producing one event per clean single-key press.
module tenkey_enc
  import seqlock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] tenkey,
  output logic       ev,
  output logic [3:0] dig
);

  logic [9:0] r_t_q;
  logic [9:0] r_t_p;

  // t_p stays all-ones after reset until the keypad is seen released, so a key
  // held through reset release never yields an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t_q <= '0;
      r_t_p <= '1;
    end else begin
      r_t_q <= tenkey;
      r_t_p <= ((&r_t_p) && (|tenkey)) ? '1 : r_t_q;
    end
  end

  assign ev  = is_onehot(r_t_q) && (r_t_p == '0);
  assign dig = keyenc(r_t_q);

endmodule

// File: rtl/seqlock.sv
// Multi-digit code lock: entry shift register, comparator, fail counter, shared timer.
module seqlock
  import seqlock_pkg::*;
#(
  parameter int unsigned         DIGITS         = 4,
  parameter logic [4*DIGITS-1:0] SECRET         = 16'h1234,
  parameter int unsigned         MAX_FAIL       = 3,
  parameter int unsigned         TIMEOUT_CYCLES = 1000,
  parameter int unsigned         LOCKOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  seqlock_if.slave   bus
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned DW   = $clog2(DIGITS + 1);
  localparam int unsigned FW   = $clog2(MAX_FAIL + 1);
  localparam int unsigned TMAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES
                                                                  : LOCKOUT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [1:0] S_IDLE    = 2'(IDLE);
  localparam logic [1:0] S_ENTRY   = 2'(ENTRY);
  localparam logic [1:0] S_OPEN    = 2'(OPEN);
  localparam logic [1:0] S_LOCKOUT = 2'(LOCKOUT);

  logic          w_ev;
  logic [3:0]    w_dig;

  logic [1:0]    r_state, w_state_d;
  logic [W-1:0]  r_entry, w_entry_d;
  logic [DW-1:0] r_digits, w_digits_d;
  logic [FW-1:0] r_fail, w_fail_d;
  logic [TW-1:0] r_timer, w_timer_d;
  logic          r_err, w_err_d;

  logic [W-1:0]  w_shift;
  logic [DW-1:0] w_cnt;
  logic [FW-1:0] w_fail_inc;
  logic [TW-1:0] w_timer_inc;

  tenkey_enc u_enc (
    .clk    (clk),
    .rst    (rst),
    .tenkey (bus.tenkey),
    .ev     (w_ev),
    .dig    (w_dig)
  );

  // A fresh attempt starts from an empty entry, so the first digit lands alone.
  assign w_shift     = (((r_state == S_IDLE) ? '0 : r_entry) << 4) | W'(w_dig);
  assign w_cnt       = (r_state == S_IDLE) ? DW'(1) : r_digits + DW'(1);
  assign w_fail_inc  = (r_fail == FW'(MAX_FAIL)) ? r_fail : r_fail + FW'(1);
  assign w_timer_inc = r_timer + TW'(1);

  always_comb begin
    w_state_d  = r_state;
    w_entry_d  = r_entry;
    w_digits_d = r_digits;
    w_fail_d   = r_fail;
    w_timer_d  = r_timer;
    w_err_d    = 1'b0;
    case (r_state)
      S_IDLE, S_ENTRY: begin
        if (w_ev) begin
          w_entry_d = w_shift;
          w_timer_d = '0;
          if (w_cnt == DW'(DIGITS)) begin
            w_digits_d = '0;
            if (w_shift == SECRET) begin
              w_state_d = S_OPEN;
              w_fail_d  = '0;
            end else begin
              w_err_d   = 1'b1;
              w_fail_d  = w_fail_inc;
              w_state_d = (w_fail_inc == FW'(MAX_FAIL)) ? S_LOCKOUT : S_IDLE;
            end
          end else begin
            w_digits_d = w_cnt;
            w_state_d  = S_ENTRY;
          end
        end else if (r_state == S_ENTRY) begin
          if (w_timer_inc == TW'(TIMEOUT_CYCLES)) begin
            w_state_d  = S_IDLE;
            w_digits_d = '0;
            w_timer_d  = '0;
          end else begin
            w_timer_d = w_timer_inc;
          end
        end
      end
      S_OPEN: begin
        if (bus.close) w_state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        if (w_timer_inc == TW'(LOCKOUT_CYCLES)) begin
          w_state_d = S_IDLE;
          w_fail_d  = '0;
          w_timer_d = '0;
        end else begin
          w_timer_d = w_timer_inc;
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_entry  <= '0;
      r_digits <= '0;
      r_fail   <= '0;
      r_timer  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_entry  <= w_entry_d;
      r_digits <= w_digits_d;
      r_fail   <= w_fail_d;
      r_timer  <= w_timer_d;
      r_err    <= w_err_d;
    end
  end

  assign bus.lock   = (r_state != S_OPEN);
  assign bus.alarm  = (r_state == S_LOCKOUT);
  assign bus.err    = r_err;
  assign bus.digits = r_digits;

endmodule

// File: tb/tb_seqlock.sv
// Directed and randomized checks of seqlock against a behavioural lock model.
module tb_seqlock;

  localparam int unsigned DIGITS = 4;
  localparam logic [15:0] SECRET = 16'h1234;
  localparam int unsigned MAX_FAIL = 3;
  localparam int TO = 20;
  localparam int LO = 50;

  localparam int MIDLE = 0;
  localparam int MENTRY = 1;
  localparam int MOPEN = 2;
  localparam int MLOCK = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  seqlock_if #(.DIGITS(DIGITS)) bus ();

  seqlock #(
    .DIGITS         (DIGITS),
    .SECRET         (SECRET),
    .MAX_FAIL       (MAX_FAIL),
    .TIMEOUT_CYCLES (TO),
    .LOCKOUT_CYCLES (LO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_err = 0;
  int n_alarm = 0;

  // Behavioural model state
  int         m_mode;
  int         m_q[$];
  int         m_idle, m_fail, m_lk;
  bit         m_err;
  logic [9:0] m_tq, m_tp;
  bit         m_blk;

  function automatic void m_reset();
    m_mode = MIDLE;
    m_q.delete();
    m_idle = 0;
    m_fail = 0;
    m_lk = 0;
    m_err = 0;
    m_tq = '0;
    m_tp = '1;
    m_blk = 1;
  endfunction

  function automatic void m_step(input logic [9:0] key, input logic cls);
    bit ev;
    int d;
    logic [15:0] v;
    ev = ($countones(m_tq) == 1) && (m_tp == 0) && !m_blk;
    d = 0;
    for (int i = 0; i < 10; i++) if (m_tq[i]) d = i;
    m_err = 0;
    if ((m_mode == MIDLE || m_mode == MENTRY) && ev) begin
      m_q.push_back(d);
      m_idle = 0;
      if (m_q.size() == DIGITS) begin
        v = '0;
        foreach (m_q[i]) v = {v[11:0], 4'(m_q[i])};
        m_q.delete();
        if (v == SECRET) begin
          m_mode = MOPEN;
          m_fail = 0;
        end else begin
          m_err = 1;
          if (m_fail < MAX_FAIL) m_fail++;
          if (m_fail >= MAX_FAIL) begin
            m_mode = MLOCK;
            m_lk = 0;
          end else begin
            m_mode = MIDLE;
          end
        end
      end else begin
        m_mode = MENTRY;
      end
    end else if (m_mode == MENTRY) begin
      m_idle++;
      if (m_idle == TO) begin
        m_mode = MIDLE;
        m_q.delete();
      end
    end else if (m_mode == MOPEN) begin
      if (cls) m_mode = MIDLE;
    end else if (m_mode == MLOCK) begin
      m_lk++;
      if (m_lk == LO) begin
        m_mode = MIDLE;
        m_fail = 0;
      end
    end
    if (!(m_blk && key != 0)) m_blk = 0;
    m_tp = m_tq;
    m_tq = key;
  endfunction

  function automatic logic exp_lock();  return m_mode != MOPEN; endfunction
  function automatic logic exp_alarm(); return m_mode == MLOCK; endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step(bus.tenkey, bus.close);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if (bus.lock !== exp_lock() || bus.alarm !== exp_alarm() || bus.err !== m_err ||
            bus.digits !== 3'(m_q.size())) begin
          errors++;
          $display("FAIL cycle t=%0t lock=%b/%b alarm=%b/%b err=%b/%b digits=%0d/%0d (got/want)",
                   $time, bus.lock, exp_lock(), bus.alarm, exp_alarm(), bus.err, m_err,
                   bus.digits, m_q.size());
        end
        if (bus.err === 1'b1) n_err++;
        if (bus.alarm === 1'b1) n_alarm++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k, input int hold, input int gap);
    bus.tenkey = 10'b1 << k;
    cyc(hold);
    bus.tenkey = '0;
    cyc(gap);
  endtask

  task automatic code(input int a, input int b, input int c, input int d);
    press(a, 3, 2);
    press(b, 3, 2);
    press(c, 3, 2);
    press(d, 3, 2);
  endtask

  task automatic close_door();
    bus.close = 1'b1;
    cyc(1);
    bus.close = 1'b0;
  endtask

  task automatic reset_now(input string name);
    #2 rst = 1'b1;
    #1;
    check({name, "-lock"}, bus.lock, 1);
    check({name, "-alarm"}, bus.alarm, 0);
    check({name, "-err"}, bus.err, 0);
    check({name, "-digits"}, bus.digits, 0);
    cyc(2);
    #2 rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int e0;
    logic [15:0] sec;
    sec = SECRET;
    bus.tenkey = '0;
    bus.close = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset-lock", bus.lock, 1);
    check("reset-alarm", bus.alarm, 0);
    check("reset-digits", bus.digits, 0);
    cyc(2);
    #2 rst = 1'b0;
    cyc(2);

    // Correct code with exact open latency
    press(1, 3, 2);
    press(2, 3, 2);
    press(3, 3, 2);
    bus.tenkey = 10'b1 << 4;
    cyc(1);
    check("open-latency-still-locked", bus.lock, 1);
    cyc(1);
    check("open-latency-unlocked", bus.lock, 0);
    check("model-open", 32'(exp_lock()), 0);
    cyc(1);
    bus.tenkey = '0;
    cyc(2);
    check("open-no-err", n_err, 0);
    close_door();
    check("close-relocks", bus.lock, 1);

    // Wrong code then correct
    code(1, 2, 3, 5);
    check("wrong-err-count", n_err, 1);
    check("wrong-locked", bus.lock, 1);
    check("wrong-digits", bus.digits, 0);
    code(1, 2, 3, 4);
    check("reopen", bus.lock, 0);
    close_door();

    // Lockout
    code(9, 9, 9, 9);
    code(9, 9, 9, 9);
    check("two-fails-no-alarm", bus.alarm, 0);
    n_alarm = 0;
    code(9, 9, 9, 9);
    check("lockout-alarm", bus.alarm, 1);
    check("model-lockout", 32'(exp_alarm()), 1);
    code(1, 2, 3, 4);
    for (int i = 0; i < 200 && bus.alarm === 1'b1; i++) cyc(1);
    check("alarm-ends", bus.alarm, 0);
    check("alarm-length", n_alarm, 50);
    code(1, 2, 3, 4);
    check("open-after-lockout", bus.lock, 0);
    close_door();

    // Inactivity timeout
    e0 = n_err;
    press(1, 3, 2);
    press(2, 3, 2);
    check("partial-digits", bus.digits, 2);
    cyc(20);
    check("timeout-digits", bus.digits, 0);
    check("timeout-no-err", n_err, e0);
    code(3, 4, 1, 2);
    check("after-timeout-err", n_err, e0 + 1);
    code(1, 2, 3, 4);
    check("after-timeout-open", bus.lock, 0);
    close_door();

    // Glitches and holds
    bus.tenkey = 10'b0000000110;
    cyc(4);
    bus.tenkey = '0;
    cyc(2);
    check("multihot-ignored", bus.digits, 0);
    bus.tenkey = 10'b1 << 1;
    cyc(15);
    check("hold-counts-once", bus.digits, 1);
    cyc(15);
    bus.tenkey = '0;
    cyc(25);
    bus.tenkey = 10'b1 << 5;
    reset_now("held-reset");
    cyc(5);
    bus.tenkey = '0;
    cyc(3);
    check("held-through-reset", bus.digits, 0);

    // Async reset in ENTRY and LOCKOUT
    press(1, 3, 2);
    press(2, 3, 2);
    check("entry-before-reset", bus.digits, 2);
    reset_now("rst-entry");
    code(9, 9, 9, 9);
    code(9, 9, 9, 9);
    code(9, 9, 9, 9);
    check("lock-before-reset", bus.alarm, 1);
    reset_now("rst-lockout");

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 9);
      bus.close = ($urandom_range(0, 3) == 0);
      if (r <= 5) begin
        press($urandom_range(0, 9), $urandom_range(1, 4), $urandom_range(0, 3));
      end else if (r == 6) begin
        int a, b;
        a = $urandom_range(0, 9);
        b = (a + 1 + $urandom_range(0, 8)) % 10;
        bus.tenkey = (10'b1 << a) | (10'b1 << b);
        cyc($urandom_range(1, 3));
        bus.tenkey = '0;
        cyc(1);
      end else if (r == 7) begin
        cyc($urandom_range(0, 25));
      end else if (r == 8) begin
        bus.close = 1'b1;
        cyc($urandom_range(1, 2));
        bus.close = 1'b0;
      end else begin
        for (int j = 0; j < 4; j++) begin
          press(int'(sec[15-4*j -: 4]), $urandom_range(1, 3), $urandom_range(1, 3));
        end
      end
    end
    bus.close = 1'b0;
    bus.tenkey = '0;
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seqlock.md
# seqlock

Parametrised multi-digit electronic lock. It accepts one-hot ten-key presses, assembles a code of `DIGITS` decimal digits and compares it to `SECRET`. After `MAX_FAIL` consecutive wrong codes it enters an alarmed lockout, and it abandons partial entries after an inactivity timeout. It is the next-generation replacement for the single-digit door lock and sits between the keypad scanner and the door actuator driver.

## Interface
- `DIGITS`, 4: number of digits per code (1..8).
- `SECRET`, 16'h1234: code as `4*DIGITS`-bit BCD. The most significant nibble is the first digit. Every nibble must be 0..9.
- `MAX_FAIL`, 3: consecutive mismatches that trigger lockout (≥1).
- `TIMEOUT_CYCLES`, 1000: idle cycles allowed between digits during entry.
- `LOCKOUT_CYCLES`, 5000: duration of lockout in cycles.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `tenkey`, input, 10: raw keypad. Bit i means key i is pressed.
- `close`, input, 1: request to re-lock (door closed).
- `lock`, output, 1: 1 means the actuator is locked.
- `alarm`, output, 1: high for the whole of lockout.
- `err`, output, 1: one-cycle pulse on a code mismatch.
- `digits`, output, `$clog2(DIGITS+1)`: number of digits entered so far in the current attempt.

## Operation
- Reset state: IDLE. `lock`=1, `alarm`=0, `err`=0, `digits`=0, fail count 0, timers 0. The key sample register is cleared to 0. The previous-sample register is set to 10'h3FF, so a key held through reset release is ignored until it is released.
- Press event:
  - Stage 1 samples `tenkey` into `t_q`. Stage 2 copies `t_q` into `t_p`.
  - An event occurs when `t_q` is exactly one-hot and `t_p`==0.
  - Multi-hot or zero patterns never produce events. Holding a key produces one event.
  - Events encode to digit 0..9.
- States:
  - IDLE (`lock`=1): an event stores the digit, sets `digits`=1 and moves to ENTRY. `close` is ignored.
  - ENTRY (`lock`=1): each event shifts the digit into the entry register and increments `digits`.
    - On the `DIGITS`-th digit, compare the whole entry with `SECRET`.
    - Match: go to OPEN and clear the fail count.
    - Mismatch: pulse `err` and increment the fail count. If the count reaches `MAX_FAIL`, go to LOCKOUT; otherwise go to IDLE.
    - Either outcome clears `digits` to 0.
    - Inactivity: if `TIMEOUT_CYCLES` cycles pass with no event, go to IDLE and clear `digits`. The fail count is unchanged and `err` does not pulse.
  - OPEN (`lock`=0): `close`=1 moves to IDLE with `lock`=1. Key events are ignored.
  - LOCKOUT (`lock`=1, `alarm`=1): events and `close` are ignored. After exactly `LOCKOUT_CYCLES` cycles, go to IDLE, clear the fail count and drop `alarm`.
- Simultaneous events:
  - Timeout expiring in the same cycle as an event: the event wins and the timer restarts.
  - `close` in the same cycle as the final matching digit: the lock opens, and `close` is not acted on until the next cycle in OPEN.
- Width rules:
  - The timer is `$clog2(max(TIMEOUT_CYCLES, LOCKOUT_CYCLES)+1)` bits and is shared between ENTRY and LOCKOUT.
  - The fail counter is `$clog2(MAX_FAIL+1)` bits and saturates at `MAX_FAIL`.

## Timing
- Digit acceptance: if a key is first sampled at edge k (into `t_q`), the event is evaluated in cycle k. `digits` and the state update at edge k+1.
- Open latency: `lock` falls at edge k+1 after the final digit's sample edge k.
- Mismatch: `err` is high for the single cycle following edge k+1.
- `close` sampled high at edge m in OPEN gives `lock`=1 after edge m.
- Timeout: IDLE is entered at the edge where the idle count equals `TIMEOUT_CYCLES`.
- Asynchronous reset mid-operation forces all outputs to their reset values immediately, with no clock required.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `seqlock_pkg`:
  - state enum {IDLE, ENTRY, OPEN, LOCKOUT};
  - `keyenc` function (10-bit one-hot to 4-bit digit);
  - `is_onehot` function.
- Sub-module `tenkey_enc`:
  - contains the two-stage sample, the press detection and the encoding;
  - outputs `ev` (1 bit) and `dig` (4 bits);
  - takes the same `clk`/`rst`.
- The top level holds the FSM, the entry shift register, the comparator, the fail counter and the shared timer.

## Test plan
Bench parameters: `DIGITS`=4, `SECRET`=16'h1234, `MAX_FAIL`=3, `TIMEOUT_CYCLES`=20, `LOCKOUT_CYCLES`=50.

- Press 1,2,3,4, each key held 3 cycles with 2 cycles of release between presses: `lock` falls 1 edge after the '4' sample edge and `err` stays 0. Then `close`=1: `lock`=1 on the next edge.
- Press 1,2,3,5: one `err` pulse, `lock` stays 1 and `digits` returns to 0. Then 1,2,3,4 opens, and the fail count is cleared.
- Three wrong codes (9,9,9,9): `alarm`=1 for exactly 50 cycles and key presses are ignored during it. Afterwards 1,2,3,4 opens.
- Press 1,2, then idle for 20 cycles: `digits` returns to 0 with no `err`. Then 3,4,1,2 gives an `err` pulse; 1,2,3,4 opens.
- Glitch and hold cases each count as a single digit or none: pattern 10'b0000000110 is ignored; key 1 held for 30 cycles counts once; a key held across reset release is ignored.
- Assert `rst` while in ENTRY (`digits`=2) and while in LOCKOUT: all outputs return to their reset values immediately.
